// File: rtl/demux_sel_sequencer.sv
// Sequencer that walks the enabled channels of a 1-to-4 demux. Each channel is held
// for a programmable dwell, and data_in is routed to the demux with one cycle of latency.
module demux_sel_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               data_in,
  output logic [1:0]         sel,
  output logic               in,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [1:0]         sel_q;
  logic               in_q;
  logic               busy_q;
  logic               done_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [3:0]         mask_q;
  logic               loop_q;

  logic [DWELL_W-1:0] dwell_d;
  logic [DWELL_W-1:0] cnt_d;
  logic [1:0]         adv_sel_d;
  logic               adv_valid_d;
  logic               dwell_end_d;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] ch;
    ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) ch = 2'(i);
    end
    return ch;
  endfunction

  // Next higher enabled channel above the current select, plus the dwell bookkeeping.
  always_comb begin
    adv_valid_d = 1'b0;
    adv_sel_d   = sel_q;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (2'(i) > sel_q)) begin
        adv_valid_d = 1'b1;
        adv_sel_d   = 2'(i);
      end
    end
    dwell_d     = (dwell == '0) ? DWELL_W'(1) : dwell;
    cnt_d       = cnt_q + DWELL_W'(1);
    dwell_end_d = (cnt_q == (dwell_q - DWELL_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      in_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= 4'd0;
      loop_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      in_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && (mask != 4'd0)) begin
            state_q <= RUN;
            mask_q  <= mask;
            loop_q  <= loop;
            dwell_q <= dwell_d;
            sel_q   <= lowest_ch(mask);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          // stop wins over any advance or completion on the same edge
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (dwell_end_d) begin
            cnt_q <= '0;
            if (adv_valid_d) begin
              sel_q <= adv_sel_d;
              in_q  <= data_in;
            end else if (loop_q) begin
              sel_q <= lowest_ch(mask_q);
              in_q  <= data_in;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
            in_q  <= data_in;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel  = sel_q;
  assign in   = in_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Directed bench for demux_sel_sequencer: expected outputs for each cycle are queued when the
// stimulus is driven and are checked once the clock edge has produced the DUT outputs.
module tb_demux_sel_sequencer;

  localparam int unsigned DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               loop;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic               data_in;
  logic [1:0]         sel;
  logic               in;
  logic               busy;
  logic               done;

  typedef struct {
    logic [1:0] sel;
    logic       in_b;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_busy = 1'b0;
  logic tg = 1'b0;

  demux_sel_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .mask(mask), .dwell(dwell), .data_in(data_in),
    .sel(sel), .in(in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Drive data_in for one edge, queue what the outputs must be afterwards, then check them.
  task automatic cyc(input logic d, input logic [1:0] es, input logic eb, input logic ed,
                     input string tag);
    exp_t e;
    data_in = d;
    e.sel   = es;
    e.busy  = eb;
    e.done  = ed;
    e.in_b  = (eb && prev_busy) ? d : 1'b0;
    sb.push_back(e);
    prev_busy = eb;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (sel === e.sel) else begin
      errors++;
      $error("FAIL %s sel got %0d exp %0d", tag, sel, e.sel);
    end
    checks++;
    assert (in === e.in_b) else begin
      errors++;
      $error("FAIL %s in got %0b exp %0b", tag, in, e.in_b);
    end
    checks++;
    assert (busy === e.busy) else begin
      errors++;
      $error("FAIL %s busy got %0b exp %0b", tag, busy, e.busy);
    end
    checks++;
    assert (done === e.done) else begin
      errors++;
      $error("FAIL %s done got %0b exp %0b", tag, done, e.done);
    end
    tg = ~tg;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    mask = 4'd0; dwell = '0; data_in = 1'b0;
    #2;

    // Reset state; reset overrides a concurrent start
    cyc(1'b0, 2'd0, 1'b0, 1'b0, "rst");
    start = 1'b1; mask = 4'b1111; dwell = 8'd2;
    cyc(1'b1, 2'd0, 1'b0, 1'b0, "rst_start");
    rst = 1'b0; start = 1'b0;
    cyc(1'b1, 2'd0, 1'b0, 1'b0, "idle_in0");

    // All channels, dwell 2, toggling data; restart and mask change mid-run are ignored
    mask = 4'b1111; dwell = 8'd2; loop = 1'b0; start = 1'b1;
    cyc(tg, 2'd0, 1'b1, 1'b0, "t1_start");
    start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      if (k == 3) begin start = 1'b1; mask = 4'b0001; dwell = 8'd1; loop = 1'b1; end
      cyc(tg, 2'(k / 2), 1'b1, 1'b0, "t1_run");
      start = 1'b0;
    end
    cyc(tg, 2'd3, 1'b0, 1'b1, "t1_done");
    cyc(tg, 2'd3, 1'b0, 1'b0, "t1_idle");

    // Loop over channels 1 and 3 with dwell 3, then stop
    mask = 4'b1010; dwell = 8'd3; loop = 1'b1; start = 1'b1;
    cyc(tg, 2'd1, 1'b1, 1'b0, "t2_start");
    start = 1'b0;
    for (int k = 1; k < 12; k++) begin
      if (k == 4) begin mask = 4'b0001; dwell = 8'd1; loop = 1'b0; end
      cyc(tg, (((k / 3) % 2) == 1) ? 2'd3 : 2'd1, 1'b1, 1'b0, "t2_loop");
    end
    stop = 1'b1;
    cyc(tg, 2'd3, 1'b0, 1'b0, "t2_stop");
    stop = 1'b0;
    cyc(tg, 2'd3, 1'b0, 1'b0, "t2_idle");

    // Dwell 0 behaves as 1; a start with mask 0 is ignored
    mask = 4'b0001; dwell = 8'd0; loop = 1'b0; start = 1'b1;
    cyc(tg, 2'd0, 1'b1, 1'b0, "t3_start");
    start = 1'b0;
    cyc(tg, 2'd0, 1'b0, 1'b1, "t3_done");
    cyc(tg, 2'd0, 1'b0, 1'b0, "t3_idle");
    mask = 4'b0000; start = 1'b1;
    cyc(tg, 2'd0, 1'b0, 1'b0, "t3_mask0");
    cyc(tg, 2'd0, 1'b0, 1'b0, "t3_mask0b");
    start = 1'b0;

    // Reset in the second RUN cycle aborts without a done pulse
    mask = 4'b1100; dwell = 8'd4; start = 1'b1;
    cyc(tg, 2'd2, 1'b1, 1'b0, "t4_start");
    start = 1'b0;
    cyc(tg, 2'd2, 1'b1, 1'b0, "t4_run");
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    cyc(tg, 2'd0, 1'b0, 1'b0, "t4_rst");
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    cyc(tg, 2'd0, 1'b0, 1'b0, "t4_idle");

    // stop on the same edge as the final completion
    mask = 4'b0011; dwell = 8'd1; loop = 1'b0; start = 1'b1;
    cyc(tg, 2'd0, 1'b1, 1'b0, "t5_start");
    start = 1'b0;
    cyc(tg, 2'd1, 1'b1, 1'b0, "t5_adv");
    stop = 1'b1;
    cyc(tg, 2'd1, 1'b0, 1'b0, "t5_stop");
    stop = 1'b0;
    cyc(tg, 2'd1, 1'b0, 1'b0, "t5_nodone");

    // A single channel in loop mode holds sel
    mask = 4'b0100; dwell = 8'd1; loop = 1'b1; start = 1'b1;
    cyc(tg, 2'd2, 1'b1, 1'b0, "t6_start");
    start = 1'b0;
    for (int k = 0; k < 6; k++) cyc(tg, 2'd2, 1'b1, 1'b0, "t6_hold");
    stop = 1'b1;
    cyc(tg, 2'd2, 1'b0, 1'b0, "t6_stop");
    stop = 1'b0;

    // Maximum dwell of 255 cycles per channel
    mask = 4'b0011; dwell = 8'd255; loop = 1'b0; start = 1'b1;
    cyc(tg, 2'd0, 1'b1, 1'b0, "t7_start");
    start = 1'b0;
    for (int k = 1; k < 510; k++) cyc(tg, (k < 255) ? 2'd0 : 2'd1, 1'b1, 1'b0, "t7_run");
    cyc(tg, 2'd1, 1'b0, 1'b1, "t7_done");
    cyc(tg, 2'd1, 1'b0, 1'b0, "t7_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
